// File: rtl/shift_unit_seq.sv
// Iterative shift unit: shifts one bit per clock (SLL/SRL/SRA/ROR) and returns
// the result through a valid/ready handshake. Accepts one request at a time.
module shift_unit_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic               busy
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;

  state_e             state_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   shift_d;
  logic [SHAMT_W-1:0] cnt_q;
  logic [1:0]         op_q;

  // Single-bit shift of the working register, selected by the latched op
  always_comb begin
    shift_d = data_q;
    unique case (op_q)
      OpSll: shift_d = {data_q[WIDTH-2:0], 1'b0};
      OpSrl: shift_d = {1'b0, data_q[WIDTH-1:1]};
      OpSra: shift_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      OpRor: shift_d = {data_q[0], data_q[WIDTH-1:1]};
      default: shift_d = data_q;
    endcase
  end

  // Control FSM plus datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_q  <= in_data;
            cnt_q   <= in_shamt;
            op_q    <= in_op;
            state_q <= (in_shamt == '0) ? StDone : StShift;
          end
        end
        StShift: begin
          data_q <= shift_d;
          cnt_q  <= cnt_q - SHAMT_W'(1);
          // cnt_q == 1 means this edge performs the final shift
          if (cnt_q == SHAMT_W'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = data_q;
  assign out_zero  = (data_q == '0);

endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Parametrised, multi-cycle shift unit for the Fusion-Core execute stage. It replaces fixed single-bit shift wiring with a WIDTH-bit iterative shifter supporting logical left, logical right, arithmetic right and rotate right by a variable amount. The unit shifts one bit position per clock and returns the result through a valid/ready handshake. It sits beside the ALU and is started by the execute control logic for shift-class instructions.

## Interface
- WIDTH, 32, data width in bits; power of two, ≥ 2
- SHAMT_W, $clog2(WIDTH), shift-amount width; not overridden independently
- clk  input  1  clock; all logic is rising-edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request; high only in IDLE
- in_data  input  WIDTH  operand to shift
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  shifted result
- out_zero  output  1  out_data == 0; qualified by out_valid
- busy  output  1  high in SHIFT or DONE

## Operation
- State machine has three states: IDLE, SHIFT and DONE. Registers are state, data_r (WIDTH), cnt_r (SHAMT_W) and op_r (2).
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: data_r←in_data, cnt_r←in_shamt, op_r←in_op.
  - Next state is DONE if in_shamt==0, else SHIFT.
- SHIFT: each cycle, data_r is shifted one bit per op_r:
  - SLL: {data_r[WIDTH-2:0],1'b0}
  - SRL: {1'b0,data_r[WIDTH-1:1]}
  - SRA: {data_r[WIDTH-1],data_r[WIDTH-1:1]}
  - ROR: {data_r[0],data_r[WIDTH-1:1]}
- SHIFT counting: cnt_r←cnt_r-1 each cycle. On the cycle cnt_r==1, the last shift occurs and the next state is DONE.
- DONE:
  - out_valid=1 and out_data=data_r. Both are held stable while out_ready=0.
  - On out_ready=1, return to IDLE.
- in_ready stays 0 in SHIFT and DONE. The unit accepts no new request in the same cycle the result is consumed.
- in_data, in_shamt and in_op are don't-care except on the accept cycle. Later changes to these inputs have no effect.
- out_data is driven from data_r in all states. out_zero is combinational on data_r.
- Reset (rst_n=0 at an edge), in any state including mid-SHIFT or DONE:
  - state→IDLE, data_r→0, cnt_r→0, op_r→0.
  - Any in-flight operation is discarded with no result.
- Reset values of outputs: in_ready=1 (IDLE), out_valid=0, out_data=0, out_zero=1, busy=0.

## Timing
- Request accepted on edge E0, i.e. in_valid & in_ready sampled high.
- Latency:
  - shamt=0: out_valid is high after E0, one cycle after request.
  - shamt=k: out_valid is high after edge Ek, k+1 cycles after the request cycle.
- Maximum latency is WIDTH cycles (shamt=WIDTH-1).
- The result is consumed on the edge where out_valid & out_ready are both high. in_ready goes high after that edge.
- Throughput is one operation per k+2 cycles with out_ready held high.
- No combinational path from in_* to out_*. in_ready depends on state only. The unit never combinationally depends on out_ready.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, out_data=0, out_zero=1, busy=0.
- SRA 0x80000010 by 4 → out_data 0xF8000001, out_valid exactly 5 cycles after the request cycle. SRL of the same operand and shift → 0x08000001.
- SLL 0x00000003 by 31 → 0x80000000 after 32 cycles. ROR 0x00000001 by 1 → 0x80000000. SLL 0x80000000 by 1 → 0x00000000 with out_zero=1.
- shamt=0, op=SRA, in_data 0xDEADBEEF → out_valid on the next cycle, out_data 0xDEADBEEF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and in_data.
  - out_data is stable and in_ready=0 throughout.
  - After out_ready=1 for one cycle, in_ready=1 and the next request is accepted.
- Reset mid-SHIFT: rst_n=0 at the 3rd shift cycle of a shift-by-20. The unit returns to IDLE with out_valid never asserted. A new request (SRL 0xF0 by 4 → 0x0F) then completes correctly.
